// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
// slave is the adder side; master is the producer/consumer side.
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_val;
  logic             in_rdy;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             cin;
  logic             out_val;
  logic             out_rdy;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport slave (
    input  in_val, in0, in1, cin, out_rdy,
    output in_rdy, out_val, sum, cout
  );

  modport master (
    output in_val, in0, in1, cin, out_rdy,
    input  in_rdy, out_val, sum, cout
  );
endinterface

// File: rtl/multicycle_adder.sv
// Digit-serial adder: {cout, sum} = in0 + in1 + cin, DIGIT bits per cycle,
// with val/rdy handshakes on both sides.
module multicycle_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_adder_if.slave bus
);
  localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 1) || ((DIGIT == 0) ? 1'b1 : ((WIDTH % DIGIT) != 0))) begin : g_param_check
    $error("multicycle_adder: WIDTH must be >= 1 and DIGIT must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_rdy_q, in_rdy_d;
  logic             out_val_q, out_val_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   step_c;

  // One digit of the ripple: low DIGIT bits of each operand plus the carry.
  assign step_c = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_val && in_rdy_q) begin
          a_d     = bus.in0;
          b_d     = bus.in1;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = (res_q >> DIGIT) | (WIDTH'(step_c[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = step_c[DIGIT];
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = step_c[DIGIT];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags follow the state being entered, so they are registered.
    in_rdy_d  = (state_d == IDLE);
    out_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b0;
      out_val_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.out_val = out_val_q;
  assign bus.sum     = res_q;
  assign bus.cout    = cout_q;
endmodule
